// File: rtl/argmax_pkg.sv
// Shared types and defaults for the digit argmax scheduler.
// Holds FSM states, compare results and default sizing.
package argmax_pkg;

  localparam int DIGIT_CLASSES = 10;
  localparam int SCORE_WIDTH   = 4;

  typedef enum logic [1:0] {
    ARG_IDLE = 2'd0,
    ARG_SCAN = 2'd1,
    ARG_DONE = 2'd2
  } arg_state_e;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_t;

  function automatic cmp_res_t cmp_decode(
    input logic gt,
    input logic lt,
    input logic eq
  );
    cmp_res_t r;
    r = CMP_LT;
    unique case (1'b1)
      gt:      r = CMP_GT;
      eq:      r = CMP_EQ;
      lt:      r = CMP_LT;
      default: r = CMP_LT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/score_compare.sv
// Unsigned magnitude compare of an incoming score against the best.
// Exactly one of gt/lt/eq is high.
module score_compare
  import argmax_pkg::*;
#(
  parameter int SCORE_W = SCORE_WIDTH
) (
  input  logic [SCORE_W-1:0] a,
  input  logic [SCORE_W-1:0] b,
  output logic               gt,
  output logic               lt,
  output logic               eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/argmax_scheduler.sv
// Streams per-class scores through one compare stage and
// reports the winning class index once the scan completes.
module argmax_scheduler
  import argmax_pkg::*;
#(
  parameter int NUM_CLASSES = DIGIT_CLASSES,
  parameter int SCORE_W     = SCORE_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score_data,
  output logic               score_ready,
  output logic               busy,
  output logic               done,
  output logic               result_valid,
  output logic [3:0]         digit,
  output logic [SCORE_W-1:0] max_score,
  output logic               tie
);

  localparam int IDX_W =
    (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_CLASSES - 1);

  arg_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]   bidx_q, bidx_d;
  logic               tier_q, tier_d;
  logic               done_q, done_d;
  logic               rv_q, rv_d;
  logic [3:0]         digit_q, digit_d;
  logic [SCORE_W-1:0] max_q, max_d;
  logic               tie_q, tie_d;

  logic     c_gt, c_lt, c_eq;
  cmp_res_t cmp;

  score_compare #(
    .SCORE_W(SCORE_W)
  ) u_cmp (
    .a (score_data),
    .b (best_q),
    .gt(c_gt),
    .lt(c_lt),
    .eq(c_eq)
  );

  assign cmp = cmp_decode(c_gt, c_lt, c_eq);

  assign score_ready  = (state_q == ARG_SCAN);
  assign busy         = (state_q == ARG_SCAN);
  assign done         = done_q;
  assign result_valid = rv_q;
  assign digit        = digit_q;
  assign max_score    = max_q;
  assign tie          = tie_q;

  // Next-state: scan sequencing, running max and result capture
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    best_d  = best_q;
    bidx_d  = bidx_q;
    tier_d  = tier_q;
    done_d  = 1'b0;
    rv_d    = rv_q;
    digit_d = digit_q;
    max_d   = max_q;
    tie_d   = tie_q;
    unique case (state_q)
      ARG_IDLE: begin
        if (start) begin
          state_d = ARG_SCAN;
          idx_d   = '0;
        end
      end
      ARG_SCAN: begin
        if (score_valid) begin
          if (idx_q == '0) begin
            best_d = score_data;
            bidx_d = '0;
            tier_d = 1'b0;
            rv_d   = 1'b0;
          end else begin
            unique case (cmp)
              CMP_GT: begin
                best_d = score_data;
                bidx_d = idx_q;
                tier_d = 1'b0;
              end
              CMP_EQ:  tier_d = 1'b1;
              default: ;
            endcase
          end
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = ARG_DONE;
            done_d  = 1'b1;
            rv_d    = 1'b1;
            digit_d = 4'(bidx_d);
            max_d   = best_d;
            tie_d   = tier_d;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ARG_DONE: begin
        idx_d   = '0;
        state_d = start ? ARG_SCAN : ARG_IDLE;
      end
      default: state_d = ARG_IDLE;
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARG_IDLE;
      idx_q   <= '0;
      best_q  <= '0;
      bidx_q  <= '0;
      tier_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      digit_q <= '0;
      max_q   <= '0;
      tie_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      best_q  <= best_d;
      bidx_q  <= bidx_d;
      tier_q  <= tier_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      digit_q <= digit_d;
      max_q   <= max_d;
      tie_q   <= tie_d;
    end
  end

endmodule

// File: tb/tb_argmax_scheduler.sv
// Randomized self-checking bench for argmax_scheduler.
// Expected results come from a plain array argmax model.
module tb_argmax_scheduler;

  localparam int N  = 10;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          score_valid;
  logic [SW-1:0] score_data;
  logic          score_ready;
  logic          busy;
  logic          done;
  logic          result_valid;
  logic [3:0]    digit;
  logic [SW-1:0] max_score;
  logic          tie;

  int n_chk = 0;
  int n_err = 0;
  int cur[N];

  argmax_scheduler #(
    .NUM_CLASSES(N),
    .SCORE_W    (SW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .score_valid (score_valid),
    .score_data  (score_data),
    .score_ready (score_ready),
    .busy        (busy),
    .done        (done),
    .result_valid(result_valid),
    .digit       (digit),
    .max_score   (max_score),
    .tie         (tie)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_max();
    int m = 0;
    foreach (cur[i]) if (cur[i] > m) m = cur[i];
    return m;
  endfunction

  function automatic int ref_digit();
    int m = ref_max();
    for (int i = 0; i < N; i++) if (cur[i] == m) return i;
    return 0;
  endfunction

  function automatic int ref_tie();
    int m = ref_max();
    int c = 0;
    foreach (cur[i]) if (cur[i] == m) c++;
    return (c > 1) ? 1 : 0;
  endfunction

  task automatic set_scores(input int s[N]);
    foreach (s[i]) cur[i] = s[i];
  endtask

  task automatic rand_scores(input int hi);
    foreach (cur[i]) cur[i] = $urandom_range(hi);
  endtask

  // One full scan; in_scan means DONE already chained into SCAN.
  task automatic do_scan(
    input bit in_scan,
    input bit chain,
    input int p_stall,
    input bit poke_start
  );
    int  i = 0;
    bit  first = 1'b1;
    int  guard = 0;
    if (!in_scan) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("ready_in_scan", score_ready, 1);
    chk("busy_in_scan", busy, 1);
    while (i < N && guard < 2000) begin
      guard++;
      score_valid = ($urandom_range(99) >= p_stall);
      score_data  = SW'(cur[i]);
      start = poke_start ? 1'($urandom_range(1)) : 1'b0;
      if (!score_ready || done) begin
        chk("scan_handshake", {score_ready, done}, 2'b10);
      end
      tick();
      if (score_valid) begin
        i++;
        if (first) begin
          chk("rv_drop_first", result_valid, 0);
          first = 1'b0;
        end
      end
    end
    if (guard >= 2000) chk("scan_guard", guard, 0);
    score_valid = 1'b0;
    start = chain;
    chk("done_pulse", done, 1);
    chk("digit", digit, ref_digit());
    chk("max_score", max_score, ref_max());
    chk("tie", tie, ref_tie());
    chk("result_valid", result_valid, 1);
    chk("busy_done", busy, 0);
    tick();
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", score_ready, chain);
    chk("rv_hold", result_valid, 1);
  endtask

  initial begin
    int s_tp[N]  = '{3, 7, 2, 9, 1, 0, 4, 8, 5, 6};
    int s_t5[N]  = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    int s_t9[N]  = '{2, 9, 9, 1, 0, 3, 4, 0, 8, 7};
    int s_t15[N] = '{9, 9, 15, 3, 1, 0, 2, 4, 6, 8};
    int s_b15[N] = '{14, 14, 14, 14, 14, 14, 14, 14, 14, 15};
    int s_z[N]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bit chained;

    rst = 1'b1;
    start = 1'b0;
    score_valid = 1'b0;
    score_data = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_outputs",
        {score_ready, busy, done, result_valid, digit, max_score, tie},
        0);

    set_scores(s_tp);
    do_scan(0, 1, 0, 0);
    set_scores(s_t5);
    do_scan(1, 1, 0, 0);
    set_scores(s_t9);
    do_scan(1, 1, 0, 0);
    set_scores(s_t15);
    do_scan(1, 0, 0, 0);

    set_scores(s_tp);
    do_scan(0, 0, 40, 1);
    set_scores(s_b15);
    do_scan(0, 0, 20, 1);
    set_scores(s_z);
    do_scan(0, 0, 0, 0);

    chained = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bit nxt = 1'($urandom_range(1));
      rand_scores((k % 3 == 0) ? 3 : 15);
      do_scan(chained, nxt, $urandom_range(60), 1'b1);
      chained = nxt;
    end
    if (chained) begin
      foreach (cur[i]) cur[i] = 1;
      do_scan(1, 0, 0, 0);
    end

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      score_valid = 1'b1;
      score_data  = 4'd15;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    score_valid = 1'b0;
    chk("reset_midscan",
        {score_ready, busy, done, result_valid, digit, max_score, tie},
        0);
    tick();
    chk("idle_after_rst", score_ready, 0);
    rand_scores(10);
    do_scan(0, 0, 10, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
